// File: rtl/aer_sched_pkg.sv
// Shared types and constants for the layer-3 AER slice event scheduler.
package aer_sched_pkg;

    localparam int NUM_SLICE   = 10;
    localparam int AER_W       = 8;
    localparam int HOT_W       = 200;
    localparam int CLASS_W     = 4;
    localparam int SLICE_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DRAIN,
        FLUSH
    } sched_state_e;

    // Round-robin pointer successor, wrapping the last lane back to lane 0.
    function automatic logic [SLICE_IDX_W-1:0] wrap_inc(input logic [SLICE_IDX_W-1:0] idx);
        logic [SLICE_IDX_W-1:0] nxt;
        nxt = idx + 1'b1;
        if (idx == SLICE_IDX_W'(NUM_SLICE - 1)) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/aer_slice_event_scheduler_rr_arbiter.sv
// Combinational 10-request round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter_10
    import aer_sched_pkg::*;
(
    input  logic [NUM_SLICE-1:0]   req,
    input  logic [SLICE_IDX_W-1:0] ptr,
    output logic [NUM_SLICE-1:0]   gnt,
    output logic [SLICE_IDX_W-1:0] gnt_idx,
    output logic                   gnt_any
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_SLICE; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_SLICE) begin
                j = j - NUM_SLICE;
            end
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = SLICE_IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/aer_slice_event_scheduler.sv
// Frame sequencer and round-robin drain for a 10-slice layer-3 AER encoder.
// Optional per-frame event cap enabled by defining AER_SCHED_MAX_EVENTS_EN.
module aer_slice_event_scheduler #(
    parameter int NUM_SLICE  = 10,
    parameter int AER_W      = 8,
    parameter int CNT_W      = 8,
    parameter int MAX_EVENTS = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              frame_valid_i,
    output logic                              frame_ready_o,
    input  logic [aer_sched_pkg::HOT_W-1:0]   frame_hot_i,
    input  logic [aer_sched_pkg::CLASS_W-1:0] frame_class_i,
    output logic                              enc_start_o,
    output logic [aer_sched_pkg::HOT_W-1:0]   enc_hot_o,
    output logic [aer_sched_pkg::CLASS_W-1:0] enc_class_o,
    input  logic [NUM_SLICE*AER_W-1:0]        enc_aer_i,
    input  logic [NUM_SLICE-1:0]              enc_valid_i,
    output logic [NUM_SLICE-1:0]              enc_on_o,
    output logic [AER_W-1:0]                  aer_o,
    output logic                              aer_valid_o,
    input  logic                              aer_ready_i,
    output logic                              frame_done_o,
    output logic [CNT_W-1:0]                  event_count_o,
    output logic                              truncated_o
);

    import aer_sched_pkg::*;

    sched_state_e           state_q, state_d;
    logic [HOT_W-1:0]       hot_q;
    logic [CLASS_W-1:0]     class_q;
    logic [SLICE_IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_SLICE-1:0]   last_gnt_q;
    logic                   aer_valid_q;
    logic [AER_W-1:0]       aer_q;
    logic                   done_q;
    logic [CNT_W-1:0]       count_q;
    logic                   trunc_q;

    logic [NUM_SLICE-1:0]   arb_req;
    logic [NUM_SLICE-1:0]   arb_gnt;
    logic [SLICE_IDX_W-1:0] arb_idx;
    logic                   arb_any;
    logic                   slot_free;
    logic                   do_grant;
    logic                   cap_hit;
    logic [AER_W-1:0]       gnt_addr;
    logic [AER_W-1:0]       lane_aer [NUM_SLICE];

    for (genvar i = 0; i < NUM_SLICE; i++) begin : g_lane
        assign lane_aer[i] = enc_aer_i[i*AER_W +: AER_W];
    end

    // A lane granted last cycle has not yet presented its next address, so mask it out.
    assign arb_req   = enc_valid_i & ~last_gnt_q;
    assign slot_free = !aer_valid_q || aer_ready_i;
    assign gnt_addr  = lane_aer[arb_idx];

    rr_arbiter_10 u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

`ifdef AER_SCHED_MAX_EVENTS_EN
    assign cap_hit = (cnt_q >= CNT_W'(MAX_EVENTS));
`else
    logic unused_max_events;
    assign cap_hit           = 1'b0;
    assign unused_max_events = ^MAX_EVENTS;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_valid_i) begin
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT:  state_d = DRAIN;
            DRAIN: begin
                if (cap_hit) begin
                    state_d = FLUSH;
                end else begin
                    do_grant = slot_free && arb_any;
                    if ((enc_valid_i == '0) && (last_gnt_q == '0)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!aer_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hot_q       <= '0;
            class_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            last_gnt_q  <= '0;
            aer_valid_q <= 1'b0;
            aer_q       <= '0;
            done_q      <= 1'b0;
            count_q     <= '0;
            trunc_q     <= 1'b0;
        end else begin
            if ((state_q == IDLE) && frame_valid_i) begin
                hot_q   <= frame_hot_i;
                class_q <= frame_class_i;
            end

            if (state_q == START) begin
                cnt_q    <= '0;
                rr_ptr_q <= '0;
            end else if (do_grant) begin
                cnt_q    <= cnt_q + 1'b1;
                rr_ptr_q <= wrap_inc(arb_idx);
            end

            last_gnt_q <= do_grant ? arb_gnt : '0;

            // A new grant refills the slot; otherwise a consumed event empties it.
            if (do_grant) begin
                aer_q       <= gnt_addr;
                aer_valid_q <= 1'b1;
            end else if (aer_ready_i) begin
                aer_valid_q <= 1'b0;
            end

            done_q <= 1'b0;
            if ((state_q == FLUSH) && !aer_valid_q) begin
                done_q  <= 1'b1;
                count_q <= cnt_q;
                trunc_q <= cap_hit && (|enc_valid_i);
            end
        end
    end

    assign frame_ready_o = (state_q == IDLE);
    assign enc_start_o   = (state_q == START);
    assign enc_on_o      = do_grant ? arb_gnt : '0;
    assign enc_hot_o     = hot_q;
    assign enc_class_o   = class_q;
    assign aer_o         = aer_q;
    assign aer_valid_o   = aer_valid_q;
    assign frame_done_o  = done_q;
    assign event_count_o = count_q;
    assign truncated_o   = trunc_q;

endmodule

// File: doc/aer_slice_event_scheduler.md
Name: aer_slice_event_scheduler

Overview:
- Sequences one layer-3 10-slice AER encoder per frame: accepts a 200-bit hot vector and error class, pulses the encoder start, then drains the encoder's 10 parallel event lanes.
- Draining uses round-robin arbitration, steering the encoder's per-slice advance (encoding_on) and serializing events onto one valid/ready AER stream.
- Sits between the layer-3 spike buffer and the off-chip/next-layer AER link.
- Reports frame completion and the per-frame event count.

Parameters:
- NUM_SLICE, 10, number of encoder lanes.
- AER_W, 8, AER address width per lane.
- CNT_W, 8, event counter width (must hold 200).
- MAX_EVENTS, 32, per-frame cap (only used with AER_SCHED_MAX_EVENTS_EN).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- frame_valid_i  in  1  new frame offered
- frame_ready_o  out  1  scheduler idle, frame accepted when valid&ready
- frame_hot_i  in  200  frame hot vector
- frame_class_i  in  4  frame error class
- enc_start_o  out  1  encoder start pulse
- enc_hot_o  out  200  hot vector to encoder (registered at accept)
- enc_class_o  out  4  error class to encoder (registered at accept)
- enc_aer_i  in  NUM_SLICE*AER_W  encoder lane addresses (output-index order)
- enc_valid_i  in  NUM_SLICE  encoder lane valids
- enc_on_o  out  NUM_SLICE  one-hot advance strobe to encoder
- aer_o  out  AER_W  serialized event address
- aer_valid_o  out  1  event valid
- aer_ready_i  in  1  downstream ready
- frame_done_o  out  1  one-cycle pulse at frame end
- event_count_o  out  CNT_W  events emitted in last frame
- truncated_o  out  1  last frame hit cap (0 when feature disabled)

Behaviour:
- Reset values: state IDLE; frame_ready_o=1; enc_start_o=0; enc_on_o=0; aer_valid_o=0; aer_o=0; frame_done_o=0; event_count_o=0; truncated_o=0; enc_hot_o=0; enc_class_o=0; rr pointer=0.
- IDLE: frame_ready_o=1. On frame_valid_i: latch hot/class, go START.
- START: enc_start_o=1 for exactly one cycle; clear counter and rr pointer; go WAIT.
- WAIT: one cycle for encoder lane registers to load; go DRAIN.
- DRAIN, grant condition: slot_free = !aer_valid_o | aer_ready_i.
- DRAIN, grant: when slot_free and enc_valid_i!=0 and no grant in the previous cycle for that same lane, the arbiter picks lane g.
  - g is the first valid lane at or after pointer, wrapping 9→0.
  - enc_on_o[g]=1 combinationally that cycle.
  - aer_o<=lane g address; aer_valid_o<=1; pointer<=(g+1) mod 10; counter++.
- DRAIN, lane re-grant block: a lane granted in cycle t is not re-granted in t+1, because its enc_valid/aer are not updated until t+1. Other lanes may be granted in t+1, so back-to-back throughput is 1 event/cycle.
- DRAIN, no grant: when slot_free is 0, enc_on_o=0 and the encoder holds.
- DRAIN, exit: when enc_valid_i==0 and no grant occurred in the previous cycle, go FLUSH.
- FLUSH: wait for aer_valid_o to drop. Then pulse frame_done_o, update event_count_o/truncated_o, go IDLE.
- aer_valid_o clears on aer_ready_i without a new grant. Output holds stable while valid & !ready.
- frame_valid_i is ignored outside IDLE.
- Reset mid-frame returns everything to reset values immediately. The encoder resets on the same reset_n.

Optional Feature:
- AER_SCHED_MAX_EVENTS_EN defined: once the counter reaches MAX_EVENTS, no further grants. DRAIN goes to FLUSH regardless of enc_valid_i, and truncated_o is set at done if any lane still valid.
- AER_SCHED_MAX_EVENTS_EN undefined: no cap; truncated_o tied 0; MAX_EVENTS unused.

Decomposition:
- Package aer_sched_pkg holds:
  - state encoding IDLE/START/WAIT/DRAIN/FLUSH;
  - constants NUM_SLICE=10, AER_W=8, HOT_W=200, CLASS_W=4.
- Sub-module rr_arbiter_10: combinational 10-request round-robin with pointer input, one-hot grant and grant index outputs. The pointer register stays in the parent.

Test Plan:
- Single event, class 0: hot bit 13 set, aer_ready_i=1 → enc_start_o one cycle after accept; one aer_o=13; frame_done_o pulse; event_count_o=1.
- Round-robin: hot bits 0, 13, 10 set (lane0 addrs 0,10; lane3 addr 13), ready=1.
  - Required stream: 0, 13, 10.
  - Lane 0 is not granted on two consecutive cycles.
  - event_count_o=3.
- Backpressure: same frame, aer_ready_i low for 5 cycles after the first valid → aer_o holds 0; enc_on_o=0 throughout; stream completes unchanged after release.
- Rotation: hot bit 0 set with class 3 → single event aer_o=0 emitted; done; count 1.
- Full density: all 200 bits set, ready=1 → 200 events, each address 0..199 exactly once; count 200; frame_ready_o low until done.
- Reset mid-DRAIN after 4 events → all outputs at reset values next cycle. A new frame then accepted normally.
- Cap test (AER_SCHED_MAX_EVENTS_EN, MAX_EVENTS=32), all bits set → exactly 32 events; truncated_o=1; count 32.
